// File: rtl/pc_gen_pkg.sv
// Shared types for the next-PC stage and its fetch/CP0 neighbours.
package pc_gen_pkg;

  typedef logic [31:0] i32;

  // Fetch-stage view of the PC stage
  typedef struct packed {
    i32 pc;
  } F_type;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } pc_gen_state_t;

  // MIPS boot vector; CP0 and exception logic reference the same constant
  localparam i32 PC_RESET_VEC = 32'hBFC0_0000;

endpackage

// File: rtl/pc_gen.sv
// Next-PC stage: owns the fetch PC, selects sequential/branch/flush targets,
// and parks a redirect that arrives while fetch is stalled on the ibus.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter i32 RESET_PC = PC_RESET_VEC
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  stall_i,
  input  i32    pc_seq_i,
  input  logic  br_valid_i,
  input  i32    br_pc_i,
  input  logic  flush_valid_i,
  input  i32    flush_pc_i,
  output F_type F,
  output logic  kill_o,
  output logic  pend_o
);

  pc_gen_state_t state_q, state_d;
  i32            pc_q, pc_d;
  i32            pend_pc_q, pend_pc_d;
  logic          pend_flush_q, pend_flush_d;

  // Next-PC selection, pending-redirect capture and squash indication
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_flush_d = pend_flush_q;

    unique case (state_q)
      RUN: begin
        if (stall_i) begin
          // Fetch cannot accept a new PC yet; remember where to go
          if (flush_valid_i) begin
            pend_pc_d    = flush_pc_i;
            pend_flush_d = 1'b1;
            state_d      = PEND;
          end else if (br_valid_i) begin
            pend_pc_d    = br_pc_i;
            pend_flush_d = 1'b0;
            state_d      = PEND;
          end
        end else if (flush_valid_i) begin
          pc_d = flush_pc_i;
        end else if (br_valid_i) begin
          pc_d = br_pc_i;
        end else begin
          pc_d = pc_seq_i;
        end
      end
      PEND: begin
        if (stall_i) begin
          // A branch here lies on the path the pending redirect supersedes
          if (flush_valid_i) begin
            pend_pc_d    = flush_pc_i;
            pend_flush_d = 1'b1;
          end
        end else begin
          pc_d         = flush_valid_i ? flush_pc_i : pend_pc_q;
          pend_flush_d = 1'b0;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // Branches never kill: the instruction in fetch is their delay slot
    kill_o = ~reset & (flush_valid_i | ((state_q == PEND) & pend_flush_q));
    pend_o = ~reset & (state_q == PEND);
    F.pc   = pc_q;
  end

  // PC, state and pending-redirect registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      pend_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_flush_q <= pend_flush_d;
    end
  end

endmodule
